can_tx: RTL
===========

CAN_TX -- requirements
Module: can_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, clocks per CAN bit time.
REQ-002 SHALL have port i_Clock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_Tx_DV  input  1  one-cycle frame-send request.
REQ-005 SHALL have port i_Tx_Id  input  11  identifier.
REQ-006 SHALL have port i_Tx_Rtr  input  1  RTR bit value.
REQ-007 SHALL have port i_Tx_Dlc  input  4  data length code.
REQ-008 SHALL have port i_Tx_Data  input  64  data field; [63] sent first.
REQ-009 SHALL have port o_Tx_Serial  output  1  bus line; 1 = recessive.
REQ-010 SHALL have port o_Tx_Active  output  1  high while a frame is on the wire.
REQ-011 SHALL have port o_Tx_Done  output  1  one-cycle pulse at frame end.

Function
REQ-012 SHALL, in IDLE, drive o_Tx_Serial=1 and o_Tx_Active=0, and SHALL accept i_Tx_DV=1 by latching all i_Tx_* inputs on that edge.
REQ-013 SHALL drive the SOF bit (0) and o_Tx_Active=1 from the clock edge after acceptance; latency is 1 cycle.
REQ-014 SHALL emit 102 unstuffed frame bits in wire order: 0 SOF=0; 1-11 Id[10:0] MSB first; 12 RTR; 13 IDE=0; 14 r0=0; 15-18 Dlc[3:0] MSB first; 19-82 Data[63:0] MSB first; 83-97 CRC[14:0] MSB first; 98 CRC delimiter=1; 99 ACK slot=1; 100 ACK delimiter=1; 101 EOF=1.
REQ-015 SHALL always send a 64-bit data field, regardless of the DLC value, including RTR=1.
REQ-016 SHALL hold each bit exactly CLKS_PER_BIT clocks, using a bit-time counter and a 7-bit frame-bit index (0..101).
REQ-017 SHALL compute CRC-15 serially: polynomial 0x4599, init 0, over unstuffed bits 0-82; CRC register is 15 bits with no reflection and no final XOR.
REQ-018 SHALL use states IDLE -> SOF -> ARB (bits 1-12) -> CTRL (13-18) -> DATA (19-82) -> CRC (83-97) -> TRAIL (98-101) -> DONE -> IDLE.
REQ-019 SHALL advance each state at the end of the last bit time of its field.
REQ-020 SHALL, in DONE, pulse o_Tx_Done=1 for exactly one cycle with o_Tx_Serial=1 and o_Tx_Active=0; a new i_Tx_DV SHALL then be acceptable in IDLE the next cycle.
REQ-021 SHALL ignore i_Tx_DV while not in IDLE; latched frame contents SHALL NOT change mid-frame.
REQ-022 SHALL NOT perform arbitration-loss detection and SHALL NOT read the bus; ACK slot driven recessive.
REQ-023 SHALL, with CLKS_PER_BIT=10, make an unstuffed frame occupy exactly 1020 clocks from SOF start to the DONE cycle.

Reset
REQ-024 SHALL, on i_Rst_n=0, immediately (asynchronously) force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, state=IDLE, and all counters and CRC to 0.
REQ-025 SHALL abandon any in-progress frame when reset is asserted mid-frame, with no o_Tx_Done; after release the block SHALL be idle and accept a new request.

Configuration
REQ-026 SHALL honour macro CAN_TX_BIT_STUFF_EN: when defined, after five consecutive identical wire bits within bits 0-97 (SOF through CRC), insert one complementary stuff bit of CLKS_PER_BIT clocks.
REQ-027 SHALL, with CAN_TX_BIT_STUFF_EN defined, exclude stuff bits from the CRC and the frame-bit index; a stuff bit SHALL start a new run of length 1; no stuffing from bit 98 onward.
REQ-028 SHALL, with CAN_TX_BIT_STUFF_EN undefined, emit exactly the 102 raw bits, matching the fixed-length can_rx frame layout.

Verification
REQ-029 Unstuffed build, Id=0x123, Rtr=0, Dlc=8, Data=0x0123456789ABCDEF, then decode with a loopback can_rx -> o_Rx_Byte bits 1-11 = 001_0010_0011, bits 15-18 = 1000, bits 19-82 match Data, o_Tx_Done after 1020 clocks.
REQ-030 CRC check, Id=0, Data=0, Dlc=0, Rtr=0 -> bits 83-97 equal the 15-bit CRC-0x4599 reference-model value over bits 0-82.
REQ-031 Stuffed build, Id=0x7FF -> wire shows SOF 0, then 1,1,1,1,1, stuff 0, then remaining ID ones; total frame length exceeds 102 bit times by the inserted stuff-bit count.
REQ-032 i_Tx_DV pulsed at wire bit 40 of an active frame -> ignored; frame unchanged; exactly one o_Tx_Done.
REQ-033 i_Rst_n low during DATA -> o_Tx_Serial=1 within the same cycle, no o_Tx_Done; after release, new request at Id=0x055 transmits a correct full frame.
REQ-034 Back-to-back: i_Tx_DV asserted the cycle after o_Tx_Done -> second SOF starts 1 cycle later; o_Tx_Active low for exactly the DONE and IDLE cycles between frames.

Source files
------------

// File: rtl/can_tx_if.sv
// Frame-request and serial-line bundle between a CAN frame source and the can_tx serializer.
interface can_tx_if;
    logic        i_Tx_DV;
    logic [10:0] i_Tx_Id;
    logic        i_Tx_Rtr;
    logic [3:0]  i_Tx_Dlc;
    logic [63:0] i_Tx_Data;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Id, i_Tx_Rtr, i_Tx_Dlc, i_Tx_Data,
        input  o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Id, i_Tx_Rtr, i_Tx_Dlc, i_Tx_Data,
        output o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
endinterface

// File: rtl/can_tx.sv
// CAN 2.0A base-frame serializer with a fixed 64-bit data field and serial CRC-15.
// Define CAN_TX_BIT_STUFF_EN to insert stuff bits from SOF through the CRC field.
module can_tx #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input logic     i_Clock,
    input logic     i_Rst_n,
    can_tx_if.slave bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = 7;
    localparam int unsigned CRC_W = 15;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SOF   = 3'd1;
    localparam logic [2:0] ST_ARB   = 3'd2;
    localparam logic [2:0] ST_CTRL  = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_CRC   = 3'd5;
    localparam logic [2:0] ST_TRAIL = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    logic [2:0]       state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [CRC_W-1:0] crc_q, crc_nx;
    logic [10:0]      id_q, id_nx;
    logic             rtr_q, rtr_nx;
    logic [3:0]       dlc_q, dlc_nx;
    logic [63:0]      data_q, data_nx;
    logic             serial_nx, active_nx, done_nx;
    logic             bit_end;
    logic             next_bit;
`ifdef CAN_TX_BIT_STUFF_EN
    logic             stuff_q, stuff_nx;
    logic             run_bit_q, run_bit_nx;
    logic [2:0]       run_len_q, run_len_nx;
`endif

    // Field state owning a given unstuffed frame-bit index.
    function automatic logic [2:0] field_state(input logic [IDX_W-1:0] idx);
        logic [2:0] s;
        if (idx == 7'd0)       s = ST_SOF;
        else if (idx <= 7'd12) s = ST_ARB;
        else if (idx <= 7'd18) s = ST_CTRL;
        else if (idx <= 7'd82) s = ST_DATA;
        else if (idx <= 7'd97) s = ST_CRC;
        else                   s = ST_TRAIL;
        return s;
    endfunction

    // Unstuffed wire value of frame bit idx; delimiters, ACK and EOF are recessive.
    function automatic logic frame_bit(input logic [IDX_W-1:0] idx, input logic [10:0] id,
                                       input logic rtr, input logic [3:0] dlc,
                                       input logic [63:0] data, input logic [CRC_W-1:0] crc);
        logic b;
        b = 1'b1;
        if (idx == 7'd0)       b = 1'b0;
        else if (idx <= 7'd11) b = id[4'(7'd11 - idx)];
        else if (idx == 7'd12) b = rtr;
        else if (idx <= 7'd14) b = 1'b0;
        else if (idx <= 7'd18) b = dlc[2'(7'd18 - idx)];
        else if (idx <= 7'd82) b = data[6'(7'd82 - idx)];
        else if (idx <= 7'd97) b = crc[4'(7'd97 - idx)];
        return b;
    endfunction

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic b);
        logic [CRC_W-1:0] c;
        c = {crc[CRC_W-2:0], 1'b0};
        if (b ^ crc[CRC_W-1]) c = c ^ CRC_POLY;
        return c;
    endfunction

    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state, bit sequencing and next registered outputs.
    always_comb begin
        state_nx  = state_q;
        cnt_nx    = cnt_q;
        idx_nx    = idx_q;
        crc_nx    = crc_q;
        id_nx     = id_q;
        rtr_nx    = rtr_q;
        dlc_nx    = dlc_q;
        data_nx   = data_q;
        serial_nx = bus.o_Tx_Serial;
        active_nx = bus.o_Tx_Active;
        done_nx   = 1'b0;
        next_bit  = 1'b1;
`ifdef CAN_TX_BIT_STUFF_EN
        stuff_nx   = stuff_q;
        run_bit_nx = run_bit_q;
        run_len_nx = run_len_q;
`endif
        case (state_q)
            ST_IDLE: begin
                serial_nx = 1'b1;
                active_nx = 1'b0;
                if (bus.i_Tx_DV) begin
                    state_nx  = ST_SOF;
                    cnt_nx    = '0;
                    idx_nx    = '0;
                    crc_nx    = '0;
                    id_nx     = bus.i_Tx_Id;
                    rtr_nx    = bus.i_Tx_Rtr;
                    dlc_nx    = bus.i_Tx_Dlc;
                    data_nx   = bus.i_Tx_Data;
                    serial_nx = 1'b0;
                    active_nx = 1'b1;
`ifdef CAN_TX_BIT_STUFF_EN
                    stuff_nx   = 1'b0;
                    run_bit_nx = 1'b0;
                    run_len_nx = 3'd1;
`endif
                end
            end
            ST_DONE: begin
                state_nx  = ST_IDLE;
                serial_nx = 1'b1;
                active_nx = 1'b0;
            end
            default: begin
                cnt_nx = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_nx = '0;
`ifdef CAN_TX_BIT_STUFF_EN
                    // A stuff bit ends: resume the frame at the already-advanced index.
                    if (stuff_q) begin
                        stuff_nx  = 1'b0;
                        next_bit  = frame_bit(idx_q, id_q, rtr_q, dlc_q, data_q, crc_q);
                        serial_nx = next_bit;
                        if (next_bit == run_bit_q) run_len_nx = run_len_q + 3'd1;
                        else begin
                            run_bit_nx = next_bit;
                            run_len_nx = 3'd1;
                        end
                    end else
`endif
                    begin
                        if (idx_q <= 7'd82) crc_nx = crc_step(crc_q, bus.o_Tx_Serial);
                        if (idx_q == 7'd101) begin
                            state_nx  = ST_DONE;
                            idx_nx    = '0;
                            serial_nx = 1'b1;
                            active_nx = 1'b0;
                            done_nx   = 1'b1;
                        end else begin
                            idx_nx   = idx_q + 7'd1;
                            state_nx = field_state(idx_nx);
`ifdef CAN_TX_BIT_STUFF_EN
                            if (run_len_q == 3'd5 && idx_q <= 7'd97) begin
                                stuff_nx   = 1'b1;
                                serial_nx  = ~run_bit_q;
                                run_bit_nx = ~run_bit_q;
                                run_len_nx = 3'd1;
                            end else
`endif
                            begin
                                next_bit  = frame_bit(idx_nx, id_q, rtr_q, dlc_q, data_q, crc_nx);
                                serial_nx = next_bit;
`ifdef CAN_TX_BIT_STUFF_EN
                                if (next_bit == run_bit_q) run_len_nx = run_len_q + 3'd1;
                                else begin
                                    run_bit_nx = next_bit;
                                    run_len_nx = 3'd1;
                                end
`endif
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            crc_q           <= '0;
            id_q            <= '0;
            rtr_q           <= 1'b0;
            dlc_q           <= '0;
            data_q          <= '0;
            bus.o_Tx_Serial <= 1'b1;
            bus.o_Tx_Active <= 1'b0;
            bus.o_Tx_Done   <= 1'b0;
`ifdef CAN_TX_BIT_STUFF_EN
            stuff_q   <= 1'b0;
            run_bit_q <= 1'b0;
            run_len_q <= '0;
`endif
        end else begin
            state_q         <= state_nx;
            cnt_q           <= cnt_nx;
            idx_q           <= idx_nx;
            crc_q           <= crc_nx;
            id_q            <= id_nx;
            rtr_q           <= rtr_nx;
            dlc_q           <= dlc_nx;
            data_q          <= data_nx;
            bus.o_Tx_Serial <= serial_nx;
            bus.o_Tx_Active <= active_nx;
            bus.o_Tx_Done   <= done_nx;
`ifdef CAN_TX_BIT_STUFF_EN
            stuff_q   <= stuff_nx;
            run_bit_q <= run_bit_nx;
            run_len_q <= run_len_nx;
`endif
        end
    end
endmodule
